// File: rtl/axis_uart_rx.sv
// UART receiver (8N1, LSB first) presenting each received word on a single-entry AXI-Stream master.
// Define AXIS_UART_RX_PARITY_EN to expect an even-parity bit before the stop bit and add parity_err.
module axis_uart_rx #(
    parameter int unsigned CLK_FREQ_HZ = 125_000_000,
    parameter int unsigned BAUD_RATE   = 9_600,
    parameter int unsigned DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_async_n,
    input  logic                  in,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    input  logic                  tready,
    output logic                  frame_err,
`ifdef AXIS_UART_RX_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        baud_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [DATA_WIDTH-1:0]   shift;
    logic                    word_done;
    logic [1:0]              rst_sync;
    logic                    rst_n;
    logic                    rx_meta;
    logic                    rx_s;
    logic                    rx_d;
`ifdef AXIS_UART_RX_PARITY_EN
    logic                    par_bit;
`endif

    // Reset asserts immediately but releases two clocks later, clean of clk.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // NOTE: the line idles high, so these flops reset to 1; resetting them to 0 would
    // fake a falling edge, i.e. a start bit, right after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= in;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every branch sees
    // the pre-edge values of rx_s, baud_cnt and bit_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            word_done  <= 1'b0;
            frame_err  <= 1'b0;
`ifdef AXIS_UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            word_done  <= 1'b0;
            frame_err  <= 1'b0;
`ifdef AXIS_UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        baud_cnt <= HALF_LOAD;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else if (!rx_s) begin
                        bit_idx  <= '0;
                        baud_cnt <= FULL_LOAD;
                        state    <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else begin
                        // Shifting in from the top leaves the first bit in bit 0 after the last shift.
                        shift    <= {rx_s, shift[DATA_WIDTH-1:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        baud_cnt <= FULL_LOAD;
                        if (bit_idx == LAST_IDX) begin
`ifdef AXIS_UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef AXIS_UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else begin
                        par_bit  <= rx_s;
                        baud_cnt <= FULL_LOAD;
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else if (rx_s) begin
                        word_done <= 1'b1;
`ifdef AXIS_UART_RX_PARITY_EN
                        parity_err <= ^{shift, par_bit};
`endif
                        state     <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single-entry output register; a completed word is dropped only when the slot stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata   <= '0;
            tvalid  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (!tvalid || tready) begin
                    tdata  <= shift;
                    tvalid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (tvalid && tready) begin
                tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_rx.sv
// Directed bench for axis_uart_rx: a word scoreboard plus per-cycle handshake/pulse rules,
// pinned with literal expectations for each scenario.
`timescale 1ns/1ps
module tb_axis_uart_rx;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DW     = 8;
    localparam int          CPB    = CLK_HZ / BAUD;
`ifdef AXIS_UART_RX_PARITY_EN
    localparam int          NBITS  = DW + 3;
`else
    localparam int          NBITS  = DW + 2;
`endif
    // Word must appear between mid stop bit and the end of the stop bit (plus sync slack).
    localparam int          LAT_MIN = (NBITS - 1) * CPB + CPB / 2;
    localparam int          LAT_MAX = NBITS * CPB + 2;

    logic          clk;
    logic          rst_async_n;
    logic          in_line;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          frame_err;
    logic          overrun;
`ifdef AXIS_UART_RX_PARITY_EN
    logic          parity_err;
`endif

    axis_uart_rx #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD_RATE  (BAUD),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst_async_n(rst_async_n),
        .in         (in_line),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tready     (tready),
        .frame_err  (frame_err),
`ifdef AXIS_UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard of words that must be handed over, in order, plus observed event counts.
    logic [DW-1:0] exp_q[$];
    int            hs_seen   = 0;
    int            ferr_seen = 0;
    int            ovr_seen  = 0;
    int            perr_seen = 0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_ferr  = 1'b0;
    logic          prev_ovr   = 1'b0;

    always @(negedge clk) begin
        if (!rst_async_n) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_ferr  <= 1'b0;
            prev_ovr   <= 1'b0;
        end else begin
            if (tvalid && tready) begin
                hs_seen <= hs_seen + 1;
                check("hs_word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("hs_tdata", tdata, exp_q.pop_front());
            end
            if (prev_valid && !prev_ready) begin
                check("stall_tvalid_held", tvalid, 1);
                check("stall_tdata_stable", tdata, prev_data);
            end
            if (frame_err) begin
                ferr_seen <= ferr_seen + 1;
                check("frame_err_one_cycle", prev_ferr, 0);
            end
            if (overrun) begin
                ovr_seen <= ovr_seen + 1;
                check("overrun_one_cycle", prev_ovr, 0);
            end
`ifdef AXIS_UART_RX_PARITY_EN
            if (parity_err) perr_seen <= perr_seen + 1;
`endif
            prev_valid <= tvalid;
            prev_ready <= tready;
            prev_data  <= tdata;
            prev_ferr  <= frame_err;
            prev_ovr   <= overrun;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        in_line = b;
        tick(CPB);
    endtask

    // Leaves the line at stop_bit, so a low stop bit keeps the line held low.
    task automatic send_frame(input logic [DW-1:0] w, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(w[i]);
`ifdef AXIS_UART_RX_PARITY_EN
        drive_bit(^w);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic wait_tvalid(input int budget, output bit found, output int lat);
        int t0;
        t0    = cyc;
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (tvalid) begin
                found = 1'b1;
                lat   = cyc - t0;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int lat;
        int lat_used;
        int base_hs;
        int base_ferr;
        int base_ovr;

        in_line     = 1'b1;
        tready      = 1'b0;
        rst_async_n = 1'b0;
        tick(3);
        check("rst_tdata", tdata, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        rst_async_n = 1'b1;
        tick(4);
        check("post_release_tvalid", tvalid, 0);

        // Basic receive with tready held high: one-cycle tvalid, correct word and latency.
        tready = 1'b1;
        exp_q.push_back(8'hC5);
        fork
            send_frame(8'hC5, 1'b1);
            begin
                wait_tvalid(2 * NBITS * CPB, found, lat);
                check("c5_tvalid_seen", found, 1);
                check("c5_tdata", tdata, 8'hC5);
                tick(1);
                check("c5_tvalid_one_clk", tvalid, 0);
            end
        join
        check("c5_latency_window", (lat >= LAT_MIN) && (lat <= LAT_MAX), 1);
        lat_used = found ? lat : LAT_MAX;
        tick(CPB);
        check("c5_handshakes", hs_seen, 1);
        check("c5_no_frame_err", ferr_seen, 0);
        check("c5_no_overrun", ovr_seen, 0);

        // Short low glitch is rejected at the mid-start-bit sample.
        base_hs   = hs_seen;
        base_ferr = ferr_seen;
        in_line   = 1'b0;
        tick(CPB / 4);
        in_line   = 1'b1;
        tick(3 * CPB);
        check("glitch_no_tvalid", tvalid, 0);
        check("glitch_no_word", hs_seen, base_hs);
        check("glitch_no_frame_err", ferr_seen, base_ferr);

        // Low stop bit, line held low: a single frame_err, then recovery on a fresh start bit.
        send_frame(8'hA5, 1'b0);
        repeat (3) drive_bit(1'b0);
        check("break_one_frame_err", ferr_seen, base_ferr + 1);
        check("break_no_tvalid", tvalid, 0);
        in_line = 1'b1;
        tick(2 * CPB);
        check("break_still_one_err", ferr_seen, base_ferr + 1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(CPB);
        check("break_recovery_word", hs_seen, base_hs + 1);

        // Stalled consumer: second word overruns and the first one is kept.
        tready   = 1'b0;
        base_hs  = hs_seen;
        base_ovr = ovr_seen;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        tick(CPB);
        check("stall_first_tvalid", tvalid, 1);
        check("stall_first_tdata", tdata, 8'h11);
        send_frame(8'h22, 1'b1);
        tick(CPB);
        check("overrun_once", ovr_seen, base_ovr + 1);
        check("overrun_kept_tdata", tdata, 8'h11);
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
        check("overrun_drain_tvalid", tvalid, 0);
        check("overrun_drain_hs", hs_seen, base_hs + 1);

        // tready raised exactly in the completion cycle of the second word.
        base_hs  = hs_seen;
        base_ovr = ovr_seen;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        tick(CPB);
        fork
            send_frame(8'h22, 1'b1);
            begin
                tick(lat_used - 1);
                tready = 1'b1;
                tick(1);
                tready = 1'b0;
                check("same_cycle_tvalid", tvalid, 1);
                check("same_cycle_tdata", tdata, 8'h22);
                check("same_cycle_first_hs", hs_seen, base_hs + 1);
            end
        join
        tick(CPB);
        check("same_cycle_no_overrun", ovr_seen, base_ovr);
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
        check("same_cycle_second_hs", hs_seen, base_hs + 2);

        // Reset in the middle of bit 4 clears a stalled word and the partial frame.
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1);
        tick(CPB);
        check("pre_reset_tvalid", tvalid, 1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        in_line = 1'b1;
        tick(CPB / 2);
        rst_async_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_tvalid", tvalid, 0);
        check("async_rst_tdata", tdata, 0);
        tick(5);
        check("rst_hold_frame_err", frame_err, 0);
        check("rst_hold_overrun", overrun, 0);
        rst_async_n = 1'b1;
        tick(2 * CPB);
        check("after_rst_idle", tvalid, 0);
        base_hs = hs_seen;
        tready  = 1'b1;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        tick(CPB);
        check("after_rst_word", hs_seen, base_hs + 1);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_frame_err_count", ferr_seen, 1);
        check("final_overrun_count", ovr_seen, 1);
`ifdef AXIS_UART_RX_PARITY_EN
        check("final_no_parity_err", perr_seen, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
